// File: rtl/i2c_slave_if.sv
// Application-side handshake between the I2C target and its host logic.
`timescale 1ns/1ps
interface i2c_slave_if;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_load;
  logic       busy;
  logic       rw;

  modport slave (
    input  tx_data,
    output rx_data,
    output rx_valid,
    output tx_load,
    output busy,
    output rw
  );

  modport master (
    output tx_data,
    input  rx_data,
    input  rx_valid,
    input  tx_load,
    input  busy,
    input  rw
  );
endinterface

// File: rtl/i2c_slave.sv
// 7-bit I2C target: oversamples SCL/SDA on clk, ACKs its own address,
// receives write bytes and serves read bytes from the host side.
`timescale 1ns/1ps
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  i2c_slave_if.slave app
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WR_DATA   = 3'd3;
  localparam logic [2:0] WR_ACK    = 3'd4;
  localparam logic [2:0] RD_DATA   = 3'd5;
  localparam logic [2:0] RD_ACK    = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_d;
  logic       sda_d;
  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  logic [2:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       sda_oe;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       tx_load_q;
  logic       busy_q;
  logic       rw_q;

  // Gating with rst_n lets reset drop the ACK without waiting for a clock.
  assign sda = (sda_oe && rst_n) ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      sda_oe     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy_q  <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_s};
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (shreg[6:0] == SLAVE_ADDR) begin
                  rw_q  <= sda_s;
                  state <= ADDR_ACK;
                end else begin
                  state <= WAIT_STOP;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          // sda_oe doubles as the phase marker: first fall starts the ACK, second ends it.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
                busy_q <= 1'b1;
              end else if (rw_q) begin
                shreg     <= app.tx_data;
                tx_load_q <= 1'b1;
                sda_oe    <= ~app.tx_data[7];
                bit_cnt   <= '0;
                state     <= RD_DATA;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= WR_DATA;
              end
            end
          end

          WR_DATA: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_s};
              if (bit_cnt == 4'd7) begin
                rx_data_q  <= {shreg[6:0], sda_s};
                rx_valid_q <= 1'b1;
                bit_cnt    <= '0;
                state      <= WR_ACK;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= WR_DATA;
              end
            end
          end

          // Bit 7 is already on the line at entry; each fall presents the next bit.
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= RD_ACK;
              end else begin
                sda_oe  <= ~shreg[6];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                state <= WAIT_STOP;
              end else begin
                bit_cnt <= 4'd1;
              end
            end else if (scl_fall && (bit_cnt == 4'd1)) begin
              shreg     <= app.tx_data;
              tx_load_q <= 1'b1;
              sda_oe    <= ~app.tx_data[7];
              bit_cnt   <= '0;
              state     <= RD_DATA;
            end
          end

          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign app.rx_data  = rx_data_q;
  assign app.rx_valid = rx_valid_q;
  assign app.tx_load  = tx_load_q;
  assign app.busy     = busy_q;
  assign app.rw       = rw_q;

  a_pulse_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(rx_valid_q && tx_load_q));

  a_pulse_state: assert property (@(posedge clk) disable iff (!rst_n)
    (rx_valid_q || tx_load_q) |-> (state != IDLE && state != WAIT_STOP));

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged bus master, a byte-level reference model and an event scoreboard.
`timescale 1ns/1ps
module tb_i2c_slave;
  localparam logic [6:0] ADDR = 7'h50;
  localparam int Q = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  sda;

  pullup pu (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_if app ();

  i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scl   (scl),
    .sda   (sda),
    .app   (app)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_tx;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] preset_q[$];
  logic [7:0] last_rx = 8'h00;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input logic is_tx, input logic [7:0] d);
    ev_t e;
    e.is_tx = is_tx;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] next_byte();
    if (preset_q.size() != 0) return preset_q.pop_front();
    return 8'($urandom);
  endfunction

  // Monitor: every host-side pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (app.rx_valid || app.tx_load)) begin
      ev_t e;
      chk("pulse_overlap", {31'b0, app.rx_valid & app.tx_load}, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {30'b0, app.rx_valid, app.tx_load}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", {31'b0, app.tx_load}, {31'b0, e.is_tx});
        if (!e.is_tx) chk("event_rx_data", {24'b0, app.rx_data}, {24'b0, e.data});
      end
    end
  end

  task automatic bit_cycle(input logic b, input bit glitch, output logic s);
    if (glitch) begin
      m_low = 1'b1; #10;
      m_low = 1'b0; #10;
      m_low = 1'b1; #10;
      m_low = ~b;   #20;
    end else begin
      m_low = ~b; #Q;
    end
    scl = 1'b1; #Q;
    s = sda;    #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic start_cond();
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic stop_cond();
    m_low = 1'b1; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b0; #Q;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], glitch, s);
    bit_cycle(1'b1, 1'b0, ack);
  endtask

  // Reference model: an address either matches or not; each written byte is
  // ACKed and delivered once; each read byte is exactly what the host supplied.
  task automatic txn(input logic [6:0] a, input logic dir, input int n,
                     input bit do_stop, input bit glitch);
    logic       ack, s;
    logic [7:0] d, nd, got;
    bit         match;
    match = (a == ADDR);
    got   = '0;
    d     = '0;
    start_cond();
    if (dir) begin
      d = next_byte();
      app.tx_data = d;
      if (match) push_ev(1'b1, d);
    end
    write_byte({a, dir}, glitch, ack);
    chk("addr_ack", {31'b0, ack}, {31'b0, !match});
    chk("busy_addr", {31'b0, app.busy}, {31'b0, match});
    if (match) chk("rw", {31'b0, app.rw}, {31'b0, dir});
    for (int k = 0; k < n; k++) begin
      if (!dir) begin
        d = next_byte();
        if (match) begin
          push_ev(1'b0, d);
          last_rx = d;
        end
        write_byte(d, glitch, ack);
        chk("data_ack", {31'b0, ack}, {31'b0, !match});
        chk("rx_data", {24'b0, app.rx_data}, {24'b0, last_rx});
        chk("busy_data", {31'b0, app.busy}, {31'b0, match});
      end else begin
        for (int i = 7; i >= 0; i--) begin
          bit_cycle(1'b1, 1'b0, s);
          got[i] = s;
        end
        nd = d;
        if (k < n - 1) begin
          nd = next_byte();
          app.tx_data = nd;
          if (match) push_ev(1'b1, nd);
        end
        bit_cycle(k == n - 1, 1'b0, s);
        if (match) begin
          chk("rd_byte", {24'b0, got}, {24'b0, d});
          if (k == n - 1) chk("sda_released", {31'b0, sda}, 1);
        end
        d = nd;
      end
    end
    if (do_stop) begin
      stop_cond();
      chk("busy_stop", {31'b0, app.busy}, 0);
    end
    chk("sb_drain", exp_q.size(), 0);
  endtask

  task automatic reset_during_ack();
    logic       s;
    logic [7:0] ab;
    ab = {ADDR, 1'b1};
    start_cond();
    for (int i = 7; i >= 0; i--) bit_cycle(ab[i], 1'b0, s);
    m_low = 1'b0; #Q;
    scl = 1'b1;   #20;
    chk("ack_before_reset", {31'b0, sda}, 0);
    rst_n = 1'b0; #1;
    chk("reset_sda", {31'b0, sda}, 1);
    chk("reset_busy", {31'b0, app.busy}, 0);
    chk("reset_rw", {31'b0, app.rw}, 0);
    chk("reset_rx_data", {24'b0, app.rx_data}, 0);
    chk("reset_rx_valid", {31'b0, app.rx_valid}, 0);
    chk("reset_tx_load", {31'b0, app.tx_load}, 0);
    last_rx = 8'h00;
    #29;
    scl = 1'b0; #Q;
    rst_n = 1'b1; #Q;
    stop_cond();
    chk("post_reset_busy", {31'b0, app.busy}, 0);
  endtask

  initial begin
    logic [6:0] a;
    app.tx_data = 8'h00;
    #100;
    chk("rst_sda", {31'b0, sda}, 1);
    chk("rst_rx_data", {24'b0, app.rx_data}, 0);
    chk("rst_rx_valid", {31'b0, app.rx_valid}, 0);
    chk("rst_tx_load", {31'b0, app.tx_load}, 0);
    chk("rst_busy", {31'b0, app.busy}, 0);
    chk("rst_rw", {31'b0, app.rw}, 0);
    rst_n = 1'b1;
    #100;

    preset_q = '{8'hA5};
    txn(ADDR, 1'b0, 1, 1'b1, 1'b0);
    chk("write_a5", {24'b0, app.rx_data}, 32'hA5);

    txn(7'h51, 1'b0, 1, 1'b1, 1'b0);

    preset_q = '{8'h3C, 8'hC3};
    txn(ADDR, 1'b1, 2, 1'b1, 1'b0);

    preset_q = '{8'h11};
    txn(ADDR, 1'b0, 1, 1'b0, 1'b0);
    chk("rw_before_rstart", {31'b0, app.rw}, 0);
    txn(ADDR, 1'b1, 1, 1'b1, 1'b0);
    chk("rx_after_rstart", {24'b0, app.rx_data}, 32'h11);

    reset_during_ack();
    txn(ADDR, 1'b0, 1, 1'b1, 1'b0);

    txn(ADDR, 1'b0, 2, 1'b1, 1'b1);

    for (int t = 0; t < 24; t++) begin
      a = ADDR;
      if ($urandom_range(0, 3) == 0) a = ADDR ^ 7'(1 << $urandom_range(0, 6));
      txn(a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
    end
    stop_cond();
    #200;

    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50: the 7-bit address this target responds to.
REQ-002 SHALL have port clk, input, 1: system clock; all state updates on its rising edge; clk SHALL be at least 10x the SCL rate.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port scl, input, 1: I2C clock from the bus; never driven.
REQ-005 SHALL have port sda, inout, 1: open-drain data; drives only 1'b0 or high-Z.
REQ-006 SHALL have port tx_data, input, 8: byte returned to the master on reads.
REQ-007 SHALL have port rx_data, output, 8: last byte written by the master.
REQ-008 SHALL have port rx_valid, output, 1: one-cycle pulse when rx_data updates.
REQ-009 SHALL have port tx_load, output, 1: one-cycle pulse when tx_data is latched.
REQ-010 SHALL have port busy, output, 1: high while addressed, from address ACK to STOP or repeated START.
REQ-011 SHALL have port rw, output, 1: R/W bit of the current transaction (1 = read).

Function
REQ-012 SHALL pass scl and sda through 2-flop synchronizers plus one history flop; edge/condition detection latency is 3 clk from the pin.
REQ-013 SHALL detect START as synchronized SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-015 On START in any state, SHALL enter ADDR, clear the bit counter, release sda and deassert busy; this covers repeated START.
REQ-016 On STOP in any state, SHALL enter IDLE and release sda.
REQ-017 ADDR SHALL shift SDA in, MSB first, on each SCL rising edge; after 8 bits it SHALL compare [7:1] with SLAVE_ADDR and latch [0] into rw.
- Match: go to ADDR_ACK.
- Mismatch: go to WAIT_STOP with sda released, ignoring the bus until START or STOP.
REQ-018 ADDR_ACK SHALL drive sda low from the 8th SCL falling edge to the 9th SCL falling edge, and assert busy at the start of ACK.
REQ-019 After address ACK with rw=0, SHALL enter WR_DATA and shift 8 bits on SCL rising edges.
REQ-020 When the 8th write bit is sampled, SHALL update rx_data and pulse rx_valid once.
REQ-021 WR_ACK SHALL always ACK (drive low) across the 9th clock, then return to WR_DATA.
REQ-022 With rw=1, SHALL latch tx_data and pulse tx_load on the address-ACK falling edge; it SHALL re-latch after each master ACK.
REQ-023 RD_DATA SHALL present bits MSB first, updating sda only after SCL falling edges.
- Bit 0 drives low.
- Bit 1 releases the line.
REQ-024 RD_ACK SHALL release sda and sample the master's bit on the 9th SCL rising edge.
- ACK (0): next byte in RD_DATA.
- NACK (1): WAIT_STOP, with no further tx_load.
REQ-025 SHALL never change sda while synchronized SCL is high, except to release it on START or STOP.
REQ-026 Bit counter SHALL be 4 bits, count 0..8, and reset to 0 on every ACK phase and on START.
REQ-027 rx_valid and tx_load SHALL never assert in the same cycle, nor while in IDLE or WAIT_STOP.

Reset
REQ-028 While rst_n=0, SHALL hold state=IDLE, sda=high-Z, rx_data=8'h00, rx_valid=0, tx_load=0, busy=0, rw=0, synchronizers=1.
REQ-029 Reset mid-transfer SHALL release sda immediately (asynchronously); after release the block SHALL ignore the bus until the next START.

Verification
REQ-030 START, 0x50+W, 0xA5, STOP -> ACK on addr and data, rx_data=8'hA5, exactly one rx_valid pulse, busy high then low after STOP.
REQ-031 START, 0x51+W -> sda high at 9th clock (NACK), busy=0, no rx_valid through the following byte and STOP.
REQ-032 START, 0x50+R, tx_data=8'h3C, master ACK, tx_data=8'hC3, master NACK, STOP -> bus bytes 3C then C3, two tx_load pulses, sda released after NACK.
REQ-033 Write 0x11, then repeated START, 0x50+R -> rx_data=8'h11, rw changes 0->1, read proceeds without an intervening STOP.
REQ-034 Assert rst_n=0 while the slave drives ACK low -> sda high-Z within the same cycle, all outputs at reset values, next valid transaction ACKed.
REQ-035 Toggle SDA while SCL is low between bits -> no false START/STOP, received byte intact.
